// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I funct3 codes for loads and stores, default widths and small helpers
// for legality and alignment decisions.
package lsu_pkg;

    localparam int ADR_W_DEF   = 12;
    localparam int TIMEOUT_DEF = 15;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Load funct3 codes
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    // Store funct3 codes
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    // True when funct3 names a real RV32I load or store.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
        else
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
    endfunction

    // Access size is encoded in funct3[1:0]: 0 byte, 1 half, 2 word.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'd1) && off[0]) || ((f3[1:0] == 2'd2) && (off != 2'd0));
    endfunction

    // Byte offset forced onto the natural boundary of the access size.
    function automatic logic [1:0] f3_align(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'd1:    return {off[1], 1'b0};
            2'd2:    return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: steers store data onto the 32-bit bus with
// matching byte enables, and extracts/extends load data from the read word.
// Offsets arriving here are already aligned to the access size.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_we_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_func3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;

    // Store: replicate the datum across the word and enable only its lanes
    always_comb begin
        st_we_o    = 4'b1111;
        st_wdata_o = st_data_i;
        case (st_size_i)
            2'd0: begin
                st_we_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            2'd1: begin
                st_we_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load: bring the addressed lane down to bit 0, then sign/zero extend
    always_comb begin
        ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        case (ld_func3_i)
            LB:      ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            LH:      ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            LBU:     ld_data_o = {24'd0, ld_shifted[7:0]};
            LHU:     ld_data_o = {16'd0, ld_shifted[15:0]};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request at a time from the execute
// stage, performs a single memory access with a bounded wait for mem_ack,
// and returns a one-cycle response to writeback.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only while idle.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of being silently aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADR_W   = ADR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_load,
    input  logic [2:0]       req_func3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [4:0]       req_rd,
    output logic             mem_en,
    output logic [3:0]       mem_we,
    output logic [ADR_W-1:0] mem_adr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic             resp_valid,
    output logic [4:0]       resp_rd,
    output logic [31:0]      resp_data,
    output logic             resp_err,
    output logic             stall,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_q, load_d;
    logic [2:0]       func3_q, func3_d;
    logic [1:0]       off_q, off_d;
    logic [4:0]       rd_q, rd_d;
    logic [3:0]       we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [31:0]      data_q, data_d;
    logic             err_q, err_d;

    logic             req_fault;
    logic [1:0]       req_off;
    logic [3:0]       st_we;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_data;
    logic [CNT_W-1:0] cnt_inc;
    logic             unused_addr;

    assign unused_addr = ^{req_addr[31:ADR_W+2]};
    assign req_off     = f3_align(req_func3, req_addr[1:0]);
    assign cnt_inc     = cnt_q + 1'b1;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_fault = !f3_legal(req_load, req_func3) || f3_misaligned(req_func3, req_addr[1:0]);
`else
    assign req_fault = !f3_legal(req_load, req_func3);
`endif

    lsu_lane_align u_lane (
        .st_size_i  (req_func3[1:0]),
        .st_off_i   (req_off),
        .st_data_i  (req_wdata),
        .st_we_o    (st_we),
        .st_wdata_o (st_wdata),
        .ld_func3_i (func3_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (mem_rdata),
        .ld_data_o  (ld_data)
    );

    // Next-state and latched-request logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        func3_d = func3_q;
        off_d   = off_q;
        rd_d    = rd_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        adr_d   = adr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load_d  = req_load;
                    func3_d = req_func3;
                    off_d   = req_off;
                    adr_d   = req_addr[ADR_W+1:2];
                    we_d    = req_load ? 4'b0000 : st_we;
                    wdata_d = req_load ? 32'd0 : st_wdata;
                    cnt_d   = '0;
                    data_d  = 32'd0;
                    if (req_fault) begin
                        // Faulting request never touches memory
                        err_d   = 1'b1;
                        rd_d    = 5'd0;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        rd_d    = req_load ? req_rd : 5'd0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    data_d  = load_q ? ld_data : 32'd0;
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    cnt_d   = cnt_inc;
                    err_d   = 1'b1;
                    rd_d    = 5'd0;
                    data_d  = 32'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            func3_q <= 3'd0;
            off_q   <= 2'd0;
            rd_q    <= 5'd0;
            we_q    <= 4'd0;
            wdata_q <= 32'd0;
            adr_q   <= '0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            func3_q <= func3_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Outputs are gated by state so idle/reset presents an all-zero bus
    assign req_ready  = (state_q == IDLE);
    assign mem_en     = (state_q == ACCESS);
    assign mem_we     = mem_en ? we_q : 4'd0;
    assign mem_adr    = mem_en ? adr_q : '0;
    assign mem_wdata  = mem_en ? wdata_q : 32'd0;
    assign resp_valid = (state_q == RESP);
    assign resp_rd    = resp_valid ? rd_q : 5'd0;
    assign resp_data  = resp_valid ? data_q : 32'd0;
    assign resp_err   = resp_valid && err_q;
    assign stall      = (state_q == ACCESS) || ((state_q == IDLE) && req_valid);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios for the
// documented examples plus randomized traffic against a behavioural model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADR_W   = 12;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_load;
    logic [2:0]       req_func3;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [4:0]       req_rd;
    logic             mem_en;
    logic [3:0]       mem_we;
    logic [ADR_W-1:0] mem_adr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             mem_ack;
    logic             resp_valid;
    logic [4:0]       resp_rd;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic             stall;
    logic [1:0]       dbg_state;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    typedef struct {
        int               resp_cyc;
        int               access_stalls;
        logic             acc_stall;
        logic             saw_en;
        logic             held_ok;
        logic [3:0]       we;
        logic [31:0]      wd;
        logic [ADR_W-1:0] adr;
        logic [31:0]      data;
        logic [4:0]       rd;
        logic             err;
        logic             post_valid;
        logic             post_ready;
    } obs_t;

    load_store_unit #(.ADR_W(ADR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .resp_valid (resp_valid),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .stall      (stall),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic legal_op(input logic ld, input logic [2:0] f3);
        if (ld) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return f3 <= 3'd2;
    endfunction

    function automatic logic traps(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        if (!legal_op(ld, f3)) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((off % size_bytes(f3)) != 0) return 1'b1;
`endif
        return (off < 0);
    endfunction

    function automatic int eff_off(input logic [2:0] f3, input logic [31:0] addr);
        int off;
        int b;
        off = int'(addr % 4);
        b = size_bytes(f3);
        return off - (off % b);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        longint v;
        longint span;
        int b;
        b = size_bytes(f3);
        span = longint'(1) << (8 * b);
        v = (longint'(rdata) >> (8 * eff_off(f3, addr))) % span;
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_we(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] w;
        int o;
        o = eff_off(f3, addr);
        w = 4'd0;
        for (int i = 0; i < 4; i++)
            if (i >= o && i < o + size_bytes(f3)) w[i] = 1'b1;
        return w;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] r;
        int src;
        r = 32'd0;
        for (int i = 0; i < 4; i++) begin
            src = i % size_bytes(f3);
            r[8*i +: 8] = data[8*src +: 8];
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // Presents one request (cycle 0), then runs cycles 1.. with mem_ack high
    // only on cycle ack_at (0 = never), recording what the DUT does.
    task automatic do_req(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int ack_at,
                          input logic [31:0] rdata, output obs_t o);
        o.resp_cyc = -1; o.access_stalls = 0; o.acc_stall = 1'b0; o.saw_en = 1'b0;
        o.held_ok = 1'b1; o.we = 4'd0; o.wd = 32'd0; o.adr = '0; o.data = 32'd0;
        o.rd = 5'd0; o.err = 1'b0; o.post_valid = 1'b0; o.post_ready = 1'b0;
        req_valid = 1'b1; req_load = ld; req_func3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd;
        #1;
        o.acc_stall = stall;
        tick;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        for (int c = 1; c <= 40; c++) begin
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? rdata : $urandom;
            #1;
            if (mem_en) begin
                if (!o.saw_en) begin
                    o.saw_en = 1'b1; o.we = mem_we; o.wd = mem_wdata; o.adr = mem_adr;
                end else if (mem_we !== o.we || mem_wdata !== o.wd || mem_adr !== o.adr) begin
                    o.held_ok = 1'b0;
                end
            end
            if (stall) o.access_stalls++;
            if (resp_valid) begin
                o.resp_cyc = c; o.data = resp_data; o.rd = resp_rd; o.err = resp_err;
                break;
            end
            tick;
        end
        mem_ack = 1'b0;
        tick;
        o.post_valid = resp_valid;
        o.post_ready = req_ready;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b0;
        tick; tick;
        checks++;
        if (req_ready !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'd0 || mem_adr !== '0 ||
            mem_wdata !== 32'd0 || resp_valid !== 1'b0 || resp_rd !== 5'd0 ||
            resp_data !== 32'd0 || resp_err !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b en=%b we=%b adr=%h wd=%h rv=%b rd=%0d data=%h err=%b stall=%b, want ready=1 all else 0",
                     req_ready, mem_en, mem_we, mem_adr, mem_wdata, resp_valid, resp_rd, resp_data, resp_err, stall);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_store_byte;
        obs_t o;
        do_req(1'b0, SB, 32'h0000_0003, 32'h0000_00A5, 5'd7, 1, 32'h0, o);
        checks++;
        if (o.we !== 4'b1000 || o.wd !== 32'hA5A5_A5A5 || o.adr !== '0) begin
            errors++;
            $display("FAIL sb_lanes: got we=%b wd=%h adr=%h, want we=1000 wd=a5a5a5a5 adr=0", o.we, o.wd, o.adr);
        end
        checks++;
        if (o.resp_cyc !== 2 || o.rd !== 5'd0 || o.err !== 1'b0 || o.data !== 32'd0) begin
            errors++;
            $display("FAIL sb_resp: got cyc=%0d rd=%0d err=%b data=%h, want cyc=2 rd=0 err=0 data=0", o.resp_cyc, o.rd, o.err, o.data);
        end
        checks++;
        if (o.acc_stall !== 1'b1 || o.post_valid !== 1'b0 || o.post_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_handshake: got accept_stall=%b post_valid=%b post_ready=%b, want 1 0 1", o.acc_stall, o.post_valid, o.post_ready);
        end
    endtask

    task automatic test_load_byte;
        obs_t o;
        do_req(1'b1, LB, 32'h0000_0006, 32'h0, 5'd9, 1, 32'h1280_3456, o);
        checks++;
        if (o.data !== 32'hFFFF_FF80 || o.rd !== 5'd9 || o.err !== 1'b0 || o.we !== 4'd0) begin
            errors++;
            $display("FAIL lb_sign: got data=%h rd=%0d err=%b we=%b, want ffffff80 9 0 0000", o.data, o.rd, o.err, o.we);
        end
        do_req(1'b1, LBU, 32'h0000_0006, 32'h0, 5'd9, 1, 32'h1280_3456, o);
        checks++;
        if (o.data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu_zero: got data=%h, want 00000080", o.data);
        end
    endtask

    task automatic test_delayed_ack;
        obs_t o;
        do_req(1'b1, LW, 32'h0000_0010, 32'h0, 5'd3, 4, 32'hDEAD_BEEF, o);
        checks++;
        if (o.resp_cyc !== 5 || o.access_stalls !== 4 || o.acc_stall !== 1'b1) begin
            errors++;
            $display("FAIL lw_delay_timing: got resp_cyc=%0d access_stalls=%0d accept_stall=%b, want 5 4 1", o.resp_cyc, o.access_stalls, o.acc_stall);
        end
        checks++;
        if (o.adr !== 12'd4 || o.data !== 32'hDEAD_BEEF || o.held_ok !== 1'b1) begin
            errors++;
            $display("FAIL lw_delay_data: got adr=%h data=%h held=%b, want 4 deadbeef 1", o.adr, o.data, o.held_ok);
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        do_req(1'b1, LW, 32'h0000_0020, 32'h0, 5'd12, 0, 32'h0, o);
        checks++;
        if (o.resp_cyc !== TIMEOUT + 1 || o.err !== 1'b1 || o.data !== 32'd0 || o.rd !== 5'd0) begin
            errors++;
            $display("FAIL timeout: got cyc=%0d err=%b data=%h rd=%0d, want cyc=%0d err=1 data=0 rd=0", o.resp_cyc, o.err, o.data, o.rd, TIMEOUT + 1);
        end
        checks++;
        if (o.post_ready !== 1'b1 || o.post_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got ready=%b valid=%b, want 1 0", o.post_ready, o.post_valid);
        end
    endtask

    task automatic test_misalign;
        obs_t o;
        do_req(1'b1, LW, 32'h0000_0002, 32'h0, 5'd5, 1, 32'h1234_5678, o);
        checks++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (o.err !== 1'b1 || o.saw_en !== 1'b0 || o.resp_cyc !== 1 || o.rd !== 5'd0) begin
            errors++;
            $display("FAIL misalign_trap: got err=%b en=%b cyc=%0d rd=%0d, want 1 0 1 0", o.err, o.saw_en, o.resp_cyc, o.rd);
        end
`else
        if (o.err !== 1'b0 || o.saw_en !== 1'b1 || o.adr !== '0 || o.data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL misalign_align: got err=%b en=%b adr=%h data=%h, want 0 1 0 12345678", o.err, o.saw_en, o.adr, o.data);
        end
`endif
    endtask

    task automatic test_illegal;
        obs_t o;
        do_req(1'b1, 3'd3, 32'h0000_0040, 32'h0, 5'd8, 1, 32'hFFFF_FFFF, o);
        checks++;
        if (o.err !== 1'b1 || o.saw_en !== 1'b0 || o.resp_cyc !== 1 || o.rd !== 5'd0 || o.data !== 32'd0) begin
            errors++;
            $display("FAIL illegal_load: got err=%b en=%b cyc=%0d rd=%0d data=%h, want 1 0 1 0 0", o.err, o.saw_en, o.resp_cyc, o.rd, o.data);
        end
        do_req(1'b0, 3'd5, 32'h0000_0040, 32'h1111_2222, 5'd8, 1, 32'h0, o);
        checks++;
        if (o.err !== 1'b1 || o.saw_en !== 1'b0 || o.resp_cyc !== 1) begin
            errors++;
            $display("FAIL illegal_store: got err=%b en=%b cyc=%0d, want 1 0 1", o.err, o.saw_en, o.resp_cyc);
        end
    endtask

    task automatic test_ack_outside;
        int spurious;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            mem_ack = 1'b1;
            mem_rdata = $urandom;
            #1;
            if (resp_valid || mem_en) spurious++;
            tick;
        end
        mem_ack = 1'b0;
        #1;
        if (resp_valid || mem_en) spurious++;
        checks++;
        if (spurious !== 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ack_outside: got spurious=%0d ready=%b, want 0 1", spurious, req_ready);
        end
        tick;
    endtask

    task automatic test_reset_in_access;
        int seen;
        req_valid = 1'b1; req_load = 1'b1; req_func3 = LW; req_addr = 32'h0000_0100;
        req_rd = 5'd4;
        tick;
        req_valid = 1'b0;
        tick;
        #1;
        checks++;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: got mem_en=%b, want 1", mem_en);
        end
        reset = 1'b0;
        tick;
        reset = 1'b1;
        checks++;
        if (mem_en !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got en=%b ready=%b valid=%b, want 0 1 0", mem_en, req_ready, resp_valid);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ack = ($urandom_range(0, 1) == 1);
            #1;
            if (resp_valid) seen++;
            tick;
        end
        mem_ack = 1'b0;
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_resp: got %0d resp_valid cycles, want 0", seen);
        end
    endtask

    task automatic test_random;
        obs_t o;
        logic ld;
        logic [2:0] f3;
        logic [31:0] addr, wd, rdata, exp_data;
        logic [4:0] rd;
        int ack_at, exp_cyc;
        logic trap, to;
        for (int n = 0; n < 60; n++) begin
            ld = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 5) == 0) f3 = 3'($urandom_range(0, 7));
            else if (ld) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end else f3 = 3'($urandom_range(0, 2));
            addr = $urandom; wd = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31));
            ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            trap = traps(ld, f3, addr);
            to = !trap && (ack_at == 0);
            exp_cyc = trap ? 1 : (to ? TIMEOUT + 1 : ack_at + 1);
            exp_data = (trap || to || !ld) ? 32'd0 : model_load(f3, addr, rdata);
            exp_q.push_back(exp_data);
            do_req(ld, f3, addr, wd, rd, ack_at, rdata, o);
            checks++;
            if (exp_q.size() == 0 || o.data !== exp_q[0] || o.resp_cyc !== exp_cyc ||
                o.err !== (trap || to) || o.rd !== ((trap || to || !ld) ? 5'd0 : rd)) begin
                errors++;
                $display("FAIL rand_resp[%0d]: ld=%b f3=%0d addr=%h got data=%h cyc=%0d err=%b rd=%0d, want data=%h cyc=%0d err=%b",
                         n, ld, f3, addr, o.data, o.resp_cyc, o.err, o.rd, exp_data, exp_cyc, trap || to);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            checks++;
            if (o.saw_en !== !trap || o.post_valid !== 1'b0 || o.post_ready !== 1'b1 ||
                o.access_stalls !== exp_cyc - 1 || o.held_ok !== 1'b1) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got en=%b post_valid=%b post_ready=%b stalls=%0d held=%b, want en=%b 0 1 stalls=%0d 1",
                         n, o.saw_en, o.post_valid, o.post_ready, o.access_stalls, o.held_ok, !trap, exp_cyc - 1);
            end
            if (!trap) begin
                checks++;
                if (o.adr !== ADR_W'(addr >> 2) ||
                    o.we !== (ld ? 4'd0 : model_we(f3, addr)) ||
                    (!ld && o.wd !== model_wdata(f3, wd))) begin
                    errors++;
                    $display("FAIL rand_bus[%0d]: got adr=%h we=%b wd=%h, want adr=%h we=%b wd=%h", n, o.adr, o.we, o.wd,
                             ADR_W'(addr >> 2), ld ? 4'd0 : model_we(f3, addr), model_wdata(f3, wd));
                end
            end
        end
    endtask

    // Sequencer
    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_func3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        test_reset;
        test_store_byte;
        test_load_byte;
        test_delayed_ack;
        test_timeout;
        test_misalign;
        test_illegal;
        test_ack_outside;
        test_reset_in_access;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
